uart_response_tx: RTL and testbench
===================================

# uart_response_tx

Serial transmitter for the host link: the outbound counterpart of the UART receive path that delivers command bytes (for example `'O'` = 79 and `'o'` = 111) to the ADC power FSM. Command handlers push response and status bytes into a small FIFO. The block serializes each byte as 8N1 on `TxD` at a fixed clocks-per-bit rate. It sits beside the receiver in the top level and drives the host-bound serial pin.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO depth; power of two, ≥ 2.
- `Clock`  in  1  system clock; all logic is on its rising edge.
- `Reset`  in  1  synchronous, active-low reset (asserted when 0).
- `Data`  in  8  byte to transmit.
- `DataValid`  in  1  write strobe; `Data` is sampled on every edge where it is high.
- `TxD`  out  1  serial line, idle high; registered.
- `Full`  out  1  FIFO holds `FIFO_DEPTH` bytes; registered.
- `Busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `Dropped`  out  1  one-cycle pulse when a write is rejected.

## Operation
- FIFO:
  - Circular buffer with read pointer, write pointer and count (width log2(`FIFO_DEPTH`)+1). Pointers wrap modulo `FIFO_DEPTH`.
  - A write is accepted when `DataValid`=1 and `Full`=0.
  - When `DataValid`=1 and `Full`=1, the byte is discarded and `Dropped`=1 for the next cycle.
  - `Full` is evaluated from the registered count. A pop in the same cycle does not free a slot for a write in that cycle.
  - A simultaneous accepted write and pop leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `TxD`=1. If the FIFO is non-empty: pop the head into the shift register, clear the bit counter, go to START.
  - START: `TxD`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `TxD`=shift[0] for `CLKS_PER_BIT` cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `TxD`=1 for `CLKS_PER_BIT` cycles. On the final stop cycle, if the FIFO is non-empty, pop and go straight to START; otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and reloads to 0 on every state or bit transition. Width is clog2(`CLKS_PER_BIT`).
- `Busy` = (state ≠ IDLE) | (count ≠ 0).
- Reset (`Reset`=0 on an edge), including mid-frame:
  - `TxD`=1, `Full`=0, `Busy`=0, `Dropped`=0.
  - State IDLE; pointers, count and counters cleared; FIFO contents flushed.
  - A frame in progress is abandoned. The line returns high on the reset edge.
  - `DataValid` is ignored while `Reset`=0.

## Timing
- Byte accepted at edge k into an empty FIFO with the FSM in IDLE:
  - Pop happens at edge k+1, and `TxD` falls at edge k+1.
  - Latency from the write edge to the start-bit edge is 1 cycle.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles: start bit + 8 data bits + 1 stop bit.
- Back-to-back frames (FIFO non-empty at the end of the stop bit) have no idle gap. The next start bit begins on the edge after the last stop cycle.
- `Full` asserts at the edge that stores the `FIFO_DEPTH`th byte. It deasserts at the edge that pops.
- `Dropped` is registered: high for exactly the one cycle after the rejected write edge.
- `Busy` falls at the edge where STOP completes with the FIFO empty.

## Test plan
Bench parameters: `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.

- **Reset values:** Hold `Reset`=0 for 3 edges, then release → `TxD`=1, `Full`=0, `Busy`=0, `Dropped`=0 throughout and after release.
- **Single byte:** Write 0x4F (`'O'`) at edge k → `TxD` is 0 over [k+1, k+5), then bits 1,1,1,1,0,0,1,0 at 4 cycles each, then stop 1 over [k+37, k+41). `Busy` falls at k+41.
- **Back-to-back:** Write 0x4F and 0x6F (`'o'`) on consecutive edges → two contiguous 40-cycle frames. The second frame's data bits are 1,1,1,1,0,1,1,0. No idle cycle between frames.
- **Full and overflow:** Write 6 bytes (0x01..0x06) on consecutive edges starting in IDLE.
  - The first byte pops at the second edge, so bytes 0x02..0x05 fill the FIFO and `Full`=1 after the fifth write.
  - The sixth write raises `Dropped` for 1 cycle.
  - Only 0x01..0x05 are transmitted, in order.
- **Simultaneous pop/write at the wrap boundary:** Run a long stream of 9 bytes, re-writing each time `Full` drops → all 9 bytes are transmitted in order with pointers wrapping twice, `Dropped` never pulses, and the count never exceeds 4.
- **Reset mid-frame:** Assert `Reset`=0 during data bit 3 of 0x4F with 2 bytes still queued → `TxD`=1 on the reset edge, `Busy`=0. After release, nothing further is transmitted.

Source files
------------

// File: rtl/uart_response_tx.sv
// uart_response_tx: a byte FIFO that feeds an 8N1 serial transmitter on the host-bound pin.
// If a byte is written while the FIFO is full, it is dropped and Dropped pulses for one cycle.
module uart_response_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Data,
    input  logic       DataValid,
    output logic       TxD,
    output logic       Full,
    output logic       Busy,
    output logic       Dropped
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    logic [1:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    bitcnt;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic          baud_done;

    // Full comes from the registered count, so a pop in this cycle cannot make room for a write in the same cycle.
    always_comb begin
        not_empty  = (count != '0);
        baud_done  = (baud == BAUD_LAST);
        push       = DataValid && !Full;
        pop        = not_empty && ((state == IDLE) || ((state == STOP) && baud_done));
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
            Full    <= 1'b0;
            Dropped <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= Data;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count   <= count_next;
            Full    <= (count_next == DEPTH_C);
            Dropped <= DataValid && Full;
        end
    end

    // TxD takes the level of the state being entered, so the line changes on the same edge as the transition.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state  <= IDLE;
            baud   <= '0;
            bitcnt <= '0;
            shift  <= '0;
            TxD    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud <= '0;
                    if (pop) begin
                        shift  <= mem[rptr];
                        bitcnt <= '0;
                        state  <= START;
                        TxD    <= 1'b0;
                    end else begin
                        TxD <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= DATA;
                        TxD   <= shift[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud   <= '0;
                        shift  <= shift >> 1;
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= STOP;
                            TxD   <= 1'b1;
                        end else begin
                            TxD <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            shift  <= mem[rptr];
                            bitcnt <= '0;
                            state  <= START;
                            TxD    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            TxD   <= 1'b1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    TxD   <= 1'b1;
                end
            endcase
        end
    end

    assign Busy = (state != IDLE) || not_empty;

endmodule

// File: tb/tb_uart_response_tx.sv
// Testbench for uart_response_tx: a queue-level reference model checks every cycle,
// a line decoder rebuilds the transmitted bytes, and literal waveforms pin key scenarios.
module tb_uart_response_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       dv  = 1'b0;
    logic [7:0] data = 8'h00;
    logic       txd;
    logic       full;
    logic       busy;
    logic       dropped;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    uart_response_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .Clock(clk), .Reset(rst), .Data(data), .DataValid(dv),
        .TxD(txd), .Full(full), .Busy(busy), .Dropped(dropped)
    );

    always #5 clk = ~clk;

    // Hand-derived LSB-first data bits for 'O' (0x4F) and 'o' (0x6F)
    bit bitsO  [8] = '{1, 1, 1, 1, 0, 0, 1, 0};
    bit bitsLo [8] = '{1, 1, 1, 1, 0, 1, 1, 0};

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic checkByte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // The reference model tracks the FIFO as a byte queue and the pin as a queue of future line levels.
    logic [7:0] mFifo[$];
    bit         mLine[$];
    logic [7:0] mByte;
    bit         mWasFull;
    bit         mTook;
    logic       expTxd  = 1'b1;
    logic       expFull = 1'b0;
    logic       expBusy = 1'b0;
    logic       expDrop = 1'b0;
    bit         modelOn = 1'b0;

    always @(posedge clk) begin
        cycle++;
        if (!rst) begin
            mFifo.delete();
            mLine.delete();
            expTxd  = 1'b1;
            expFull = 1'b0;
            expBusy = 1'b0;
            expDrop = 1'b0;
            modelOn = 1'b1;
        end else if (modelOn) begin
            mWasFull = (mFifo.size() == DEPTH);
            mTook    = 1'b0;
            if (mLine.size() == 0 && mFifo.size() != 0) begin
                mByte = mFifo.pop_front();
                for (int j = 0; j < CPB; j++) mLine.push_back(1'b0);
                for (int b = 0; b < 8; b++)
                    for (int j = 0; j < CPB; j++) mLine.push_back(mByte[b]);
                for (int j = 0; j < CPB; j++) mLine.push_back(1'b1);
            end
            expDrop = dv && mWasFull;
            if (dv && !mWasFull) mFifo.push_back(data);
            if (mLine.size() != 0) begin
                expTxd = mLine.pop_front();
                mTook  = 1'b1;
            end else begin
                expTxd = 1'b1;
            end
            expFull = (mFifo.size() == DEPTH);
            expBusy = mTook || (mFifo.size() != 0);
        end
    end

    int dropSeen = 0;

    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("modelTxd", txd, expTxd);
            checkOutput("modelFull", full, expFull);
            checkOutput("modelBusy", busy, expBusy);
            checkOutput("modelDropped", dropped, expDrop);
            if (dropped === 1'b1) dropSeen++;
        end
    end

    // Line decoder: phase 0 is the first start-bit sample; data bit i is sampled mid-bit at phase 4*i+6.
    int         rxPhase = -1;
    logic [7:0] rxShift = 8'h00;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (!rst) begin
            rxPhase = -1;
        end else if (rxPhase < 0) begin
            if (txd === 1'b0) rxPhase = 0;
        end else begin
            rxPhase++;
            if ((rxPhase % 4) == 2 && rxPhase >= 6 && rxPhase <= 34) rxShift = {txd, rxShift[7:1]};
            if (rxPhase == 39) begin
                rxq.push_back(rxShift);
                rxPhase = -1;
            end
        end
    end

    function automatic logic expLine(input int n, input int frames);
        int p;
        int f;
        p = (n - 1) % 40;
        f = (n - 1) / 40;
        if (n < 1 || f >= frames) return 1'b1;
        if (p < 4) return 1'b0;
        if (p >= 36) return 1'b1;
        return (f == 0) ? bitsO[(p - 4) / 4] : bitsLo[(p - 4) / 4];
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        data = b;
        dv   = 1'b1;
        @(posedge clk);
        #1;
        dv = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int g;
        g = 0;
        while ((busy !== 1'b0 || rxPhase >= 0) && g < budget) begin
            @(negedge clk);
            g++;
        end
        checkOutput("drainBusy", busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int g;
        logic [7:0] tmp;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("rstTxd", txd, 1'b1);
            checkOutput("rstFull", full, 1'b0);
            checkOutput("rstBusy", busy, 1'b0);
            checkOutput("rstDropped", dropped, 1'b0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("relTxd", txd, 1'b1);
        checkOutput("relBusy", busy, 1'b0);

        // Single byte 'O'
        base = rxq.size();
        applyStimulus(8'h4F);
        #4;
        checkOutput("singlePreTxd", txd, 1'b1);
        checkOutput("singlePreBusy", busy, 1'b1);
        for (int n = 1; n <= 41; n++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("singleTxd", txd, expLine(n, 1));
            checkOutput("singleBusy", busy, (n <= 40) ? 1'b1 : 1'b0);
        end
        checkByte("singleCount", 8'(rxq.size() - base), 8'd1);
        if (rxq.size() > base) checkByte("singleByte", rxq[base], 8'h4F);

        // Back-to-back 'O' then 'o'
        base = rxq.size();
        applyStimulus(8'h4F);
        applyStimulus(8'h6F);
        for (int n = 2; n <= 81; n++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("b2bTxd", txd, expLine(n, 2));
            checkOutput("b2bBusy", busy, (n <= 80) ? 1'b1 : 1'b0);
        end
        checkByte("b2bCount", 8'(rxq.size() - base), 8'd2);
        if (rxq.size() > base + 1) begin
            checkByte("b2bByte0", rxq[base], 8'h4F);
            checkByte("b2bByte1", rxq[base + 1], 8'h6F);
        end

        // Fill and overflow
        base = rxq.size();
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
        checkOutput("fullAfter5", full, 1'b1);
        checkOutput("noDropYet", dropped, 1'b0);
        applyStimulus(8'h06);
        checkOutput("dropAfter6", dropped, 1'b1);
        checkOutput("fullAfter6", full, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("dropOneCycle", dropped, 1'b0);
        waitDrain(400);
        checkByte("ovfCount", 8'(rxq.size() - base), 8'd5);
        for (int i = 0; i < 5; i++)
            if (base + i < rxq.size()) checkByte("ovfByte", rxq[base + i], 8'(i + 1));

        // Long stream refilled whenever Full drops, wrapping the pointers twice
        base = rxq.size();
        g = dropSeen;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            int w;
            w = 0;
            while (full === 1'b1 && w < 100) begin
                @(posedge clk);
                #1;
                w++;
            end
            checkOutput("wrapFullWait", full, 1'b0);
            applyStimulus(8'(8'hA0 + i));
        end
        waitDrain(600);
        checkOutput("wrapNoDrop", (dropSeen != g), 1'b0);
        checkByte("wrapCount", 8'(rxq.size() - base), 8'd9);
        for (int i = 0; i < 9; i++)
            if (base + i < rxq.size()) checkByte("wrapByte", rxq[base + i], 8'(8'hA0 + i));

        // Reset during data bit 3 of 'O' with two bytes queued
        base = rxq.size();
        @(posedge clk);
        #1;
        applyStimulus(8'h4F);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("midBit3", txd, bitsO[3]);
        checkOutput("midBusy", busy, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #4;
        checkOutput("midRstTxd", txd, 1'b1);
        checkOutput("midRstBusy", busy, 1'b0);
        checkOutput("midRstFull", full, 1'b0);
        checkOutput("midRstDropped", dropped, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (120) @(negedge clk);
        checkOutput("afterRstBusy", busy, 1'b0);
        checkOutput("afterRstTxd", txd, 1'b1);
        tmp = 8'(rxq.size() - base);
        checkByte("afterRstCount", tmp, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
